wgt_pingpong_rf: RTL and testbench
==================================

Name: wgt_pingpong_rf

Overview:
- Double-buffered weight register file feeding one PE row of the systolic array.
- Generalises the single weight shift RF with two changes:
  - a programmable kernel length up to BUFFER_SIZE;
  - a valid/ready load port that fills a shadow bank while the active bank recirculates weights to the PE.
- A swap at a pass boundary promotes the shadow bank, so weight reload for the next layer or filter is hidden behind compute.

Parameters:
- DATA_WIDTH, 8, weight word width.
- BUFFER_SIZE, 27, maximum weights per kernel per bank (3x3x3).
- LEN_W, 5, width of cfg_len; must satisfy 2^LEN_W > BUFFER_SIZE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_len  in  LEN_W  kernel length for the bank being loaded; sampled on the first accepted load beat.
- wgt_in_valid  in  1  load beat valid.
- wgt_in_ready  out  1  shadow bank can accept a beat.
- wgt_in_data  in  DATA_WIDTH  weight word.
- wgt_RF_shift_en  in  1  advance the active bank by one weight (recirculating).
- swap_req  in  1  request promotion of the shadow bank.
- swap_ack  out  1  one-cycle pulse; the swap happened this cycle.
- shadow_full  out  1  shadow bank holds a complete kernel.
- data_out  out  DATA_WIDTH  current weight of the active bank.
- data_out_valid  out  1  active bank holds a kernel.
- pass_done  out  1  one-cycle pulse when the active read index wraps to 0.

Behaviour:
- Storage and pointers:
  - Two banks, each BUFFER_SIZE x DATA_WIDTH. bank_sel selects the active bank.
  - Active bank: read pointer rd_ptr; wr_ptr and shadow_len belong to the shadow bank.
  - Physical shifting is replaced by circular indexing; the output sequence is identical to a recirculating shift register.
- Reset (rst_n=0 at a clk edge):
  - bank_sel=0, rd_ptr=0, wr_ptr=0, active_len=1, shadow_len=1.
  - shadow_full=0, data_out_valid=0, swap_ack=0, pass_done=0.
  - Bank contents are not cleared. data_out reads 0 whenever data_out_valid=0.
  - A reset mid-load or mid-pass discards all progress.
- Length clamp on the sampled cfg_len: 0 -> 1; values > BUFFER_SIZE -> BUFFER_SIZE.
- Load:
  - wgt_in_ready = !shadow_full (combinational from the register).
  - A beat is accepted when valid && ready. It writes shadow[wr_ptr], then wr_ptr++.
  - On the first beat (wr_ptr==0), the clamped cfg_len is latched into shadow_len.
  - When the accepted beat has wr_ptr==shadow_len-1: wr_ptr<=0 and shadow_full<=1 on the next edge.
  - cfg_len changes mid-load are ignored.
- Swap condition, evaluated each cycle (a swap needs shadow_full=1):
  - first load: data_out_valid=0 and shadow_full=1 (automatic, no swap_req needed); or
  - swap_req=1 at a pass boundary: rd_ptr==0, or a shift this cycle that wraps rd_ptr to 0.
- On swap:
  - bank_sel toggles, active_len<=shadow_len, rd_ptr<=0.
  - shadow_full<=0, data_out_valid<=1, swap_ack=1 for that cycle.
  - The old active bank becomes the shadow; wgt_in_ready rises the next cycle.
- swap_req while shadow_full=0, or off a pass boundary: ignored, not latched. The requester holds swap_req until swap_ack.
- Shift:
  - Acts only when data_out_valid=1: rd_ptr <= (rd_ptr==active_len-1) ? 0 : rd_ptr+1.
  - On wrap, pass_done=1 for the next cycle (registered).
  - Shift when data_out_valid=0: ignored.
- Simultaneous shift-with-wrap and swap:
  - The swap wins: rd_ptr<=0 in the new bank.
  - pass_done still pulses for the completed pass.
- data_out = active[rd_ptr], a combinational read of registers. It is valid in the cycle after a swap or shift edge, i.e. 1-cycle latency from the shift_en edge.
- active_len=1: every shift wraps, so pass_done stays high while shift_en is held.
- Load and shift in the same cycle are independent; they always target different banks.

Decomposition:
- Shared package wgt_rf_pkg:
  - DATA_WIDTH and BUFFER_SIZE defaults;
  - the LEN_W derivation function (clog2);
  - the length clamp function.
- One sub-module, wgt_rf_bank: a single BUFFER_SIZE-entry register bank with write port (we, waddr, wdata) and async read port (raddr, rdata). It is instantiated twice.
- Pointer, length, swap and handshake control stay in the top module.

Test Plan:
- Reset then load with cfg_len=27, data 1..27, valid held high:
  - ready drops after beat 27; auto-swap gives swap_ack one cycle later;
  - data_out=1, valid=1.
- Shift_en held 30 cycles after the first load:
  - data_out follows 1..27,1,2,3; pass_done pulses once after 27 shifts.
- While rotating, load cfg_len=9 with data 40..48, then hold swap_req:
  - swap_ack occurs only on the cycle rd_ptr wraps;
  - data_out=40 next; subsequent pass_done every 9 shifts.
- Edge cases:
  - swap_req with shadow empty -> no swap_ack, rotation unchanged;
  - cfg_len=0 -> length 1, data_out constant, pass_done high every shift;
  - cfg_len=31 -> clamped to 27.
- Backpressure and reset:
  - toggle valid randomly during a 27-beat load -> contents match the accepted beats in order, no loss or duplication;
  - rst_n=0 for one edge after beat 13 -> ready=1, valid=0, and a fresh full load is required.
- Shift_en held at swap:
  - wrap and swap in the same cycle -> pass_done=1, new bank data_out = its element 0, no element skipped.

Source files
------------

// File: rtl/wgt_rf_pkg.sv
// Shared defaults and helpers for the ping-pong weight RF.
// Provides width derivation and kernel-length clamping.
package wgt_rf_pkg;

  localparam int WGT_DATA_WIDTH  = 8;
  localparam int WGT_BUFFER_SIZE = 27;

  // Smallest width whose range exceeds n (so n itself fits).
  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Length 0 means a single weight; anything past the bank depth
  // is limited to the bank depth.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/wgt_pingpong_rf_if.sv
// Load / rotate / swap bundle of the ping-pong weight RF.
// master drives load, shift and swap requests; slave is the RF.
interface wgt_pingpong_rf_if
  import wgt_rf_pkg::*;
#(
  parameter int DATA_WIDTH = WGT_DATA_WIDTH,
  parameter int LEN_W      = len_w(WGT_BUFFER_SIZE)
);

  logic [LEN_W-1:0]      cfg_len;
  logic                  wgt_in_valid;
  logic                  wgt_in_ready;
  logic [DATA_WIDTH-1:0] wgt_in_data;
  logic                  wgt_RF_shift_en;
  logic                  swap_req;
  logic                  swap_ack;
  logic                  shadow_full;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  pass_done;

  modport master (
    output cfg_len, wgt_in_valid, wgt_in_data,
    output wgt_RF_shift_en, swap_req,
    input  wgt_in_ready, swap_ack, shadow_full,
    input  data_out, data_out_valid, pass_done
  );

  modport slave (
    input  cfg_len, wgt_in_valid, wgt_in_data,
    input  wgt_RF_shift_en, swap_req,
    output wgt_in_ready, swap_ack, shadow_full,
    output data_out, data_out_valid, pass_done
  );

endinterface

// File: rtl/wgt_rf_bank.sv
// One weight bank: DEPTH x DATA_WIDTH registers, no reset.
// Ports: i_we/i_waddr/i_wdata write, i_raddr/o_rdata async read.
module wgt_rf_bank
  import wgt_rf_pkg::*;
#(
  parameter int DATA_WIDTH = WGT_DATA_WIDTH,
  parameter int DEPTH      = WGT_BUFFER_SIZE,
  parameter int AW         = len_w(WGT_BUFFER_SIZE)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wgt_pingpong_rf.sv
// Double-buffered weight RF: shadow bank loads while active rotates.
// Ports: clk, rst_n (sync, low) and the slave side of the RF bundle.
module wgt_pingpong_rf
  import wgt_rf_pkg::*;
#(
  parameter int DATA_WIDTH  = WGT_DATA_WIDTH,
  parameter int BUFFER_SIZE = WGT_BUFFER_SIZE,
  parameter int LEN_W       = len_w(WGT_BUFFER_SIZE)
) (
  input logic              clk,
  input logic              rst_n,
  wgt_pingpong_rf_if.slave bus
);

  logic                  r_bank_sel;
  logic [LEN_W-1:0]      r_rd_ptr;
  logic [LEN_W-1:0]      r_wr_ptr;
  logic [LEN_W-1:0]      r_active_len;
  logic [LEN_W-1:0]      r_shadow_len;
  logic                  r_shadow_full;
  logic                  r_valid;
  logic                  r_pass_done;

  logic                  w_ready;
  logic                  w_load;
  logic                  w_first;
  logic                  w_last;
  logic                  w_shift;
  logic                  w_wrap;
  logic                  w_boundary;
  logic                  w_swap;
  logic [LEN_W-1:0]      w_cfg_len;
  logic [LEN_W-1:0]      w_load_len;
  logic [DATA_WIDTH-1:0] w_rdata0;
  logic [DATA_WIDTH-1:0] w_rdata1;

  assign w_ready = !r_shadow_full;
  assign w_load  = bus.wgt_in_valid && w_ready;
  assign w_first = (r_wr_ptr == '0);

  assign w_cfg_len =
    LEN_W'(clamp_len(int'(bus.cfg_len), BUFFER_SIZE));

  // Length is only taken from cfg_len on the first beat.
  assign w_load_len = w_first ? w_cfg_len : r_shadow_len;
  assign w_last = (r_wr_ptr == w_load_len - LEN_W'(1));

  assign w_shift = bus.wgt_RF_shift_en && r_valid;
  assign w_wrap  = w_shift &&
                   (r_rd_ptr == r_active_len - LEN_W'(1));

  assign w_boundary = (r_rd_ptr == '0) || w_wrap;

  // First kernel promotes itself; later ones wait for a
  // requested pass boundary.
  assign w_swap = rst_n && r_shadow_full &&
                  (!r_valid || (bus.swap_req && w_boundary));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank_sel    <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_active_len  <= LEN_W'(1);
      r_shadow_len  <= LEN_W'(1);
      r_shadow_full <= 1'b0;
      r_valid       <= 1'b0;
      r_pass_done   <= 1'b0;
    end else begin
      r_pass_done <= w_wrap;
      // A swap overrides the wrap: new bank starts at 0.
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_active_len  <= r_shadow_len;
        r_rd_ptr      <= '0;
        r_shadow_full <= 1'b0;
        r_valid       <= 1'b1;
      end else if (w_shift) begin
        r_rd_ptr <= w_wrap ? '0 : r_rd_ptr + LEN_W'(1);
      end
      // Load and swap are exclusive: one needs full, one !full.
      if (w_load) begin
        if (w_first) r_shadow_len <= w_cfg_len;
        if (w_last) begin
          r_wr_ptr      <= '0;
          r_shadow_full <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + LEN_W'(1);
        end
      end
    end
  end

  wgt_rf_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUFFER_SIZE),
    .AW        (LEN_W)
  ) u_bank0 (
    .clk    (clk),
    .i_we   (w_load && r_bank_sel),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.wgt_in_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata0)
  );

  wgt_rf_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUFFER_SIZE),
    .AW        (LEN_W)
  ) u_bank1 (
    .clk    (clk),
    .i_we   (w_load && !r_bank_sel),
    .i_waddr(r_wr_ptr),
    .i_wdata(bus.wgt_in_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata1)
  );

  assign bus.wgt_in_ready   = w_ready;
  assign bus.swap_ack       = w_swap;
  assign bus.shadow_full    = r_shadow_full;
  assign bus.data_out_valid = r_valid;
  assign bus.pass_done      = r_pass_done;
  assign bus.data_out       = !r_valid  ? '0 :
                              r_bank_sel ? w_rdata1 : w_rdata0;

endmodule

// File: tb/tb_wgt_pingpong_rf.sv
// Directed bench for wgt_pingpong_rf.
// Covers load, rotate, swap at wrap, clamp, backpressure, reset.
module tb_wgt_pingpong_rf;
  import wgt_rf_pkg::*;

  localparam int DW = 8;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  wgt_pingpong_rf_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus();

  wgt_pingpong_rf #(
    .DATA_WIDTH (DW),
    .BUFFER_SIZE(27),
    .LEN_W      (LW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input int cfg, input int base,
                             input int n, input bit rnd,
                             output int ncyc);
    int idx;
    idx = 0;
    ncyc = 0;
    while (idx < n && ncyc < 300) begin
      bus.cfg_len = (rnd && idx > 0) ? LW'($urandom)
                                     : LW'(cfg);
      bus.wgt_in_data = DW'(base + idx);
      bus.wgt_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.wgt_in_valid && bus.wgt_in_ready) idx++;
      cyc();
      ncyc++;
    end
    bus.wgt_in_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errs++;
      $display("FAIL load_done beats=%0d exp=%0d", idx, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cfg_len = '0;
    bus.wgt_in_valid = 1'b0;
    bus.wgt_in_data = '0;
    bus.wgt_RF_shift_en = 1'b0;
    bus.swap_req = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    checks++;
    if (bus.wgt_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_ready got=%b exp=1", bus.wgt_in_ready);
    end
    checks++;
    if (bus.shadow_full !== 1'b0) begin
      errs++;
      $display("FAIL rst_full got=%b exp=0", bus.shadow_full);
    end
    checks++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'd0) begin
      errs++;
      $display("FAIL rst_out v=%b d=%0d exp v=0 d=0",
               bus.data_out_valid, bus.data_out);
    end
    checks++;
    if (bus.pass_done !== 1'b0 || bus.swap_ack !== 1'b0) begin
      errs++;
      $display("FAIL rst_pulses pd=%b ack=%b exp 0 0",
               bus.pass_done, bus.swap_ack);
    end
  endtask

  task automatic test_first_load();
    int nc;
    load_kernel(27, 1, 27, 1'b0, nc);
    checks++;
    if (nc != 27) begin
      errs++;
      $display("FAIL first_cycles got=%0d exp=27", nc);
    end
    checks++;
    if (bus.wgt_in_ready !== 1'b0 || bus.shadow_full !== 1'b1) begin
      errs++;
      $display("FAIL first_full rdy=%b full=%b exp 0 1",
               bus.wgt_in_ready, bus.shadow_full);
    end
    #1;
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errs++;
      $display("FAIL first_autoswap got=%b exp=1", bus.swap_ack);
    end
    cyc();
    checks++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'd1) begin
      errs++;
      $display("FAIL first_out v=%b d=%0d exp v=1 d=1",
               bus.data_out_valid, bus.data_out);
    end
    checks++;
    if (bus.swap_ack !== 1'b0 || bus.wgt_in_ready !== 1'b1) begin
      errs++;
      $display("FAIL first_post ack=%b rdy=%b exp 0 1",
               bus.swap_ack, bus.wgt_in_ready);
    end
  endtask

  task automatic test_rotate();
    int pulses;
    int exp_d;
    pulses = 0;
    bus.wgt_RF_shift_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      exp_d = (k % 27) + 1;
      checks++;
      if (bus.data_out !== DW'(exp_d)) begin
        errs++;
        $display("FAIL rot_data k=%0d got=%0d exp=%0d",
                 k, bus.data_out, exp_d);
      end
      if (bus.pass_done === 1'b1) begin
        pulses++;
        checks++;
        if (k != 27) begin
          errs++;
          $display("FAIL rot_pd_pos k=%0d exp=27", k);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL rot_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_swap_at_wrap();
    int nc;
    int w;
    int pulses;
    int exp_d;
    load_kernel(9, 40, 9, 1'b0, nc);
    checks++;
    if (bus.data_out !== 8'd13 || bus.shadow_full !== 1'b1) begin
      errs++;
      $display("FAIL sw_loaded d=%0d full=%b exp d=13 full=1",
               bus.data_out, bus.shadow_full);
    end
    w = 0;
    bus.swap_req = 1'b1;
    while (w < 40) begin
      #1;
      if (bus.swap_ack === 1'b1) break;
      w++;
      cyc();
    end
    checks++;
    if (w != 14) begin
      errs++;
      $display("FAIL sw_wait got=%0d exp=14", w);
    end
    cyc();
    bus.swap_req = 1'b0;
    checks++;
    if (bus.pass_done !== 1'b1 || bus.data_out !== 8'd40) begin
      errs++;
      $display("FAIL sw_wrap pd=%b d=%0d exp pd=1 d=40",
               bus.pass_done, bus.data_out);
    end
    pulses = 0;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      exp_d = 40 + (k % 9);
      checks++;
      if (bus.data_out !== DW'(exp_d)) begin
        errs++;
        $display("FAIL sw_data k=%0d got=%0d exp=%0d",
                 k, bus.data_out, exp_d);
      end
      if (bus.pass_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errs++;
      $display("FAIL sw_pulses got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_swap_empty();
    int acks;
    acks = 0;
    bus.swap_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.swap_ack === 1'b1) acks++;
      cyc();
    end
    bus.swap_req = 1'b0;
    bus.wgt_RF_shift_en = 1'b0;
    checks++;
    if (acks != 0) begin
      errs++;
      $display("FAIL empty_ack got=%0d exp=0", acks);
    end
    checks++;
    if (bus.data_out !== 8'd43 || bus.pass_done !== 1'b0) begin
      errs++;
      $display("FAIL empty_rot d=%0d pd=%b exp d=43 pd=0",
               bus.data_out, bus.pass_done);
    end
  endtask

  task automatic test_len_zero();
    int nc;
    int w;
    load_kernel(0, 77, 1, 1'b0, nc);
    checks++;
    if (bus.wgt_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL len0_ready got=%b exp=0", bus.wgt_in_ready);
    end
    bus.wgt_RF_shift_en = 1'b1;
    bus.swap_req = 1'b1;
    w = 0;
    while (w < 40) begin
      #1;
      if (bus.swap_ack === 1'b1) break;
      w++;
      cyc();
    end
    checks++;
    if (w != 5) begin
      errs++;
      $display("FAIL len0_wait got=%0d exp=5", w);
    end
    cyc();
    bus.swap_req = 1'b0;
    checks++;
    if (bus.data_out !== 8'd77 || bus.pass_done !== 1'b1) begin
      errs++;
      $display("FAIL len0_swap d=%0d pd=%b exp d=77 pd=1",
               bus.data_out, bus.pass_done);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (bus.data_out !== 8'd77 || bus.pass_done !== 1'b1) begin
        errs++;
        $display("FAIL len0_shift k=%0d d=%0d pd=%b exp 77 1",
                 k, bus.data_out, bus.pass_done);
      end
    end
    bus.wgt_RF_shift_en = 1'b0;
  endtask

  task automatic test_len_clamp();
    int nc;
    int pulses;
    int exp_d;
    load_kernel(31, 100, 27, 1'b0, nc);
    checks++;
    if (bus.wgt_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL clamp_ready got=%b exp=0", bus.wgt_in_ready);
    end
    bus.swap_req = 1'b1;
    #1;
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errs++;
      $display("FAIL clamp_ack got=%b exp=1", bus.swap_ack);
    end
    cyc();
    bus.swap_req = 1'b0;
    checks++;
    if (bus.data_out !== 8'd100 || bus.pass_done !== 1'b0) begin
      errs++;
      $display("FAIL clamp_swap d=%0d pd=%b exp d=100 pd=0",
               bus.data_out, bus.pass_done);
    end
    pulses = 0;
    bus.wgt_RF_shift_en = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      cyc();
      exp_d = 100 + (k % 27);
      checks++;
      if (bus.data_out !== DW'(exp_d)) begin
        errs++;
        $display("FAIL clamp_data k=%0d got=%0d exp=%0d",
                 k, bus.data_out, exp_d);
      end
      if (bus.pass_done === 1'b1) pulses++;
    end
    bus.wgt_RF_shift_en = 1'b0;
    checks++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL clamp_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_backpressure();
    int nc;
    load_kernel(27, 200, 27, 1'b1, nc);
    checks++;
    if (bus.wgt_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_ready got=%b exp=0", bus.wgt_in_ready);
    end
    bus.swap_req = 1'b1;
    #1;
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errs++;
      $display("FAIL bp_ack got=%b exp=1", bus.swap_ack);
    end
    cyc();
    bus.swap_req = 1'b0;
    for (int k = 0; k < 27; k++) begin
      checks++;
      if (bus.data_out !== DW'(200 + k)) begin
        errs++;
        $display("FAIL bp_data k=%0d got=%0d exp=%0d",
                 k, bus.data_out, 200 + k);
      end
      bus.wgt_RF_shift_en = 1'b1;
      cyc();
    end
    bus.wgt_RF_shift_en = 1'b0;
  endtask

  task automatic test_reset_midload();
    int nc;
    load_kernel(27, 50, 13, 1'b0, nc);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++;
    if (bus.wgt_in_ready !== 1'b1 || bus.shadow_full !== 1'b0) begin
      errs++;
      $display("FAIL mrst_load rdy=%b full=%b exp 1 0",
               bus.wgt_in_ready, bus.shadow_full);
    end
    checks++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'd0) begin
      errs++;
      $display("FAIL mrst_out v=%b d=%0d exp 0 0",
               bus.data_out_valid, bus.data_out);
    end
    bus.wgt_RF_shift_en = 1'b1;
    cyc();
    bus.wgt_RF_shift_en = 1'b0;
    checks++;
    if (bus.data_out !== 8'd0 || bus.pass_done !== 1'b0) begin
      errs++;
      $display("FAIL mrst_shift d=%0d pd=%b exp 0 0",
               bus.data_out, bus.pass_done);
    end
    load_kernel(27, 50, 27, 1'b0, nc);
    checks++;
    if (nc != 27 || bus.wgt_in_ready !== 1'b0) begin
      errs++;
      $display("FAIL mrst_reload cycles=%0d rdy=%b exp 27 0",
               nc, bus.wgt_in_ready);
    end
    #1;
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errs++;
      $display("FAIL mrst_ack got=%b exp=1", bus.swap_ack);
    end
    cyc();
    checks++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'd50) begin
      errs++;
      $display("FAIL mrst_out2 v=%b d=%0d exp 1 50",
               bus.data_out_valid, bus.data_out);
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_rotate();
    test_swap_at_wrap();
    test_swap_empty();
    test_len_zero();
    test_len_clamp();
    test_backpressure();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
